// File: rtl/mest_pro_collector_pkg.sv
// Shared types and helpers for the mest_pro result collector.
//   collector_state_t : collector FSM encoding
//   entry_width()     : FIFO entry width, {carry, zero, result}
//   checksum_step()   : one rotate-left-by-one then XOR checksum update
package mest_pro_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } collector_state_t;

    // Carry and zero flags ride above the result in every FIFO entry.
    localparam int FLAG_BITS = 2;

    function automatic int entry_width(input int data_width);
        return data_width + FLAG_BITS;
    endfunction

    // Operates on a 64-bit carrier so one function serves any counter width
    // up to 64; the caller truncates the result back to its own width.
    function automatic logic [63:0] checksum_step(input logic [63:0] cur,
                                                  input logic [63:0] res,
                                                  input int          width);
        logic [63:0] mask;
        logic [63:0] rot;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        rot  = ((cur << 1) | (cur >> (width - 1))) & mask;
        return rot ^ (res & mask);
    endfunction

endpackage

// File: rtl/mest_pro_result_collector_if.sv
// Drain-side valid/ready stream of the result collector.
//   o_data       : head FIFO entry {carry, zero, result}
//   o_data_valid : FIFO not empty
//   i_data_ready : consumer accepts o_data on this edge
// master = collector, slave = host / scoreboard.
interface mest_pro_result_collector_if
    import mest_pro_collector_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    localparam int ENTRY_WIDTH = entry_width(DATA_WIDTH);

    logic [ENTRY_WIDTH-1:0] o_data;
    logic                   o_data_valid;
    logic                   i_data_ready;

    modport master (output o_data, output o_data_valid, input i_data_ready);
    modport slave  (input o_data, input o_data_valid, output i_data_ready);

endinterface

// File: rtl/mest_pro_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-around pointers (extra MSB).
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous flush, same effect as rst on the pointers
//   push/wdata : write request; accepted when not full or when popping
//   pop/rdata  : read request; rdata shows the head entry, 0 when empty
//   level      : occupancy 0..DEPTH
//   full/empty : occupancy flags
//   pop_ok     : a pop is taken on this edge
module mest_pro_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     pop_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    // When full, the slot being popped is the one written, so the pop frees room.
    assign push_ok = push && (!full || pop_ok);
    // Memory is not reset; gating keeps the head at 0 whenever nothing is buffered.
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mest_pro_result_collector.sv
// Collects the mest_pro core result stream into a FIFO, keeps a per-run
// result count and rotate-XOR checksum, and drains entries over a
// valid/ready stream. Raises a sticky done once the run ends and the FIFO
// has emptied.
//   clk, i_reset               : clock, synchronous active-high reset
//   i_start                    : begin a new run (clears FIFO and statistics)
//   i_result/i_valid_result    : core result and strobe
//   i_carry/i_zero_flag        : core flags captured with the strobe
//   i_all_done                 : core end of program
//   drain                      : {carry, zero, result} output stream
//   o_count/o_checksum         : per-run statistics
//   o_level/o_overflow/o_done  : FIFO occupancy, sticky drop flag, run complete
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | after reset; strobes ignored, waiting for i_start
// ST_COLLECT | strobes pushed into the FIFO, count/checksum updated
// ST_DRAIN   | core finished; strobes ignored, waiting for FIFO to empty
// ST_DONE    | run complete, FIFO empty, o_done high
module mest_pro_result_collector
    import mest_pro_collector_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [DATA_WIDTH-1:0]         i_result,
    input  logic                          i_valid_result,
    input  logic                          i_carry,
    input  logic                          i_zero_flag,
    input  logic                          i_all_done,
    mest_pro_result_collector_if.master   drain,
    output logic [CNT_WIDTH-1:0]          o_count,
    output logic [CNT_WIDTH-1:0]          o_checksum,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic                          o_done
);
    localparam int ENTRY_WIDTH = entry_width(DATA_WIDTH);
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;

    collector_state_t       state_q, state_d;
    logic                   clear_run;
    logic                   accept;
    logic                   drained;
    logic [ENTRY_WIDTH-1:0] fifo_rdata;
    logic [LW-1:0]          fifo_level;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop_ok;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [CNT_WIDTH-1:0]   checksum_q;
    logic                   overflow_q;

    mest_pro_sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (i_reset),
        .clear  (clear_run),
        .push   (accept),
        .wdata  ({i_carry, i_zero_flag, i_result}),
        .pop    (drain.i_data_ready),
        .rdata  (fifo_rdata),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .pop_ok (fifo_pop_ok)
    );

    // Emptiness as it will be after this edge's pop, so DONE follows the last pop directly.
    assign drained = fifo_empty || ((fifo_level == LW'(1)) && fifo_pop_ok);

    always_ff @(posedge clk) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        clear_run = 1'b0;
        accept    = 1'b0;
        if (i_start) begin
            state_d   = ST_COLLECT;
            clear_run = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_COLLECT: begin
                    accept = i_valid_result;
                    if (i_all_done) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drained) state_d = ST_DONE;
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Count and checksum follow every accepted strobe, dropped or not.
    always_ff @(posedge clk) begin
        if (i_reset || clear_run) begin
            count_q    <= '0;
            checksum_q <= '0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            if (count_q != '1) count_q <= count_q + 1'b1;
            checksum_q <= CNT_WIDTH'(checksum_step(64'(checksum_q), 64'(i_result), CNT_WIDTH));
            if (fifo_full && !fifo_pop_ok) overflow_q <= 1'b1;
        end
    end

    assign drain.o_data       = fifo_rdata;
    assign drain.o_data_valid = !fifo_empty;
    assign o_count            = count_q;
    assign o_checksum         = checksum_q;
    assign o_level            = fifo_level;
    assign o_overflow         = overflow_q;
    assign o_done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_mest_pro_result_collector.sv
module tb_mest_pro_result_collector;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [DW-1:0] i_result;
    logic          i_valid_result;
    logic          i_carry;
    logic          i_zero_flag;
    logic          i_all_done;
    logic [CW-1:0] o_count;
    logic [CW-1:0] o_checksum;
    logic [LW-1:0] o_level;
    logic          o_overflow;
    logic          o_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW+1:0] got[$];

    always #5 clk = ~clk;

    mest_pro_result_collector_if #(.DATA_WIDTH(DW)) bus ();

    mest_pro_result_collector #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_result       (i_result),
        .i_valid_result (i_valid_result),
        .i_carry        (i_carry),
        .i_zero_flag    (i_zero_flag),
        .i_all_done     (i_all_done),
        .drain          (bus),
        .o_count        (o_count),
        .o_checksum     (o_checksum),
        .o_level        (o_level),
        .o_overflow     (o_overflow),
        .o_done         (o_done)
    );

    // Records the word popped on the coming edge, then advances one cycle.
    task automatic tick();
        if (bus.o_data_valid && bus.i_data_ready) got.push_back(bus.o_data);
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] r, input logic c, input logic z);
        i_valid_result = 1'b1;
        i_result       = r;
        i_carry        = c;
        i_zero_flag    = z;
        tick();
        i_valid_result = 1'b0;
        i_result       = '0;
        i_carry        = 1'b0;
        i_zero_flag    = 1'b0;
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        got.delete();
    endtask

    task automatic drain_all(input int bound, input string tag);
        int n = 0;
        bus.i_data_ready = 1'b1;
        while (bus.o_data_valid && n < bound) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus.o_data_valid) begin
            n_bad++;
            $display("FAIL %s_drain_timeout: level=%0d after %0d cycles, want 0", tag, o_level, n);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        n_cmp++;
        if ({bus.o_data, bus.o_data_valid, o_count, o_checksum, o_level, o_overflow, o_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: data=%h valid=%b count=%h chk=%h level=%0d ovf=%b done=%b, want all 0",
                     bus.o_data, bus.o_data_valid, o_count, o_checksum, o_level, o_overflow, o_done);
        end
        bus.i_data_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_valid_result = (i % 2 == 0);
            i_result       = 8'h5A;
            tick();
            n_cmp++;
            if ({o_level, o_count, bus.o_data_valid, o_done} !== '0) begin
                n_bad++;
                $display("FAIL idle_ignore[%0d]: level=%0d count=%0d valid=%b done=%b, want 0 0 0 0",
                         i, o_level, o_count, bus.o_data_valid, o_done);
            end
        end
        i_valid_result = 1'b0;
        i_result       = '0;
    endtask

    task automatic test_basic();
        logic [DW+1:0] exp_w [3];
        exp_w[0] = 10'h001;
        exp_w[1] = 10'h002;
        exp_w[2] = 10'h280;
        bus.i_data_ready = 1'b1;
        start_run();
        strobe(8'h01, 1'b0, 1'b0);
        strobe(8'h02, 1'b0, 1'b0);
        strobe(8'h80, 1'b1, 1'b0);
        tick();
        tick();
        n_cmp++;
        if (o_count !== 16'd3) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want 3", o_count);
        end
        // 0x0001 -> rotate 0x0002 ^ 0x02 = 0x0000 -> ^ 0x80 = 0x0080
        n_cmp++;
        if (o_checksum !== 16'h0080) begin
            n_bad++;
            $display("FAIL basic_checksum: got %h want 0080", o_checksum);
        end
        n_cmp++;
        if (got.size() != 3) begin
            n_bad++;
            $display("FAIL basic_word_count: got %0d want 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                n_cmp++;
                if (got[i] !== exp_w[i]) begin
                    n_bad++;
                    $display("FAIL basic_word[%0d]: got %h want %h", i, got[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [4:0]    kv;
        logic [DW+1:0] e;
        start_run();
        bus.i_data_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            kv = 5'(i);
            strobe(8'(8'h10 + kv), kv[0], kv[1]);
        end
        n_cmp++;
        if ({o_level, o_overflow, o_count, bus.o_data_valid, bus.o_data} !== {5'd16, 1'b1, 16'd20, 1'b1, 10'h010}) begin
            n_bad++;
            $display("FAIL overflow_state: level=%0d ovf=%b count=%0d valid=%b data=%h, want 16 1 20 1 010",
                     o_level, o_overflow, o_count, bus.o_data_valid, bus.o_data);
        end
        drain_all(40, "overflow");
        n_cmp++;
        if (got.size() != 16) begin
            n_bad++;
            $display("FAIL overflow_drained: got %0d words want 16", got.size());
        end
        for (int k = 0; k < 16; k++) begin
            if (k < got.size()) begin
                kv = 5'(k);
                e  = {kv[0], kv[1], 8'(8'h10 + kv)};
                n_cmp++;
                if (got[k] !== e) begin
                    n_bad++;
                    $display("FAIL overflow_word[%0d]: got %h want %h", k, got[k], e);
                end
            end
        end
        n_cmp++;
        if ({o_overflow, o_count} !== {1'b1, 16'd20}) begin
            n_bad++;
            $display("FAIL overflow_sticky: ovf=%b count=%0d, want 1 20", o_overflow, o_count);
        end
    endtask

    task automatic test_full_pop_push();
        start_run();
        n_cmp++;
        if ({o_overflow, o_count, o_checksum, o_level} !== '0) begin
            n_bad++;
            $display("FAIL restart_clear: ovf=%b count=%0d chk=%h level=%0d, want all 0",
                     o_overflow, o_count, o_checksum, o_level);
        end
        bus.i_data_ready = 1'b0;
        for (int i = 0; i < 16; i++) strobe(8'(8'hA0 + i), 1'b0, 1'b0);
        n_cmp++;
        if ({o_level, o_overflow} !== {5'd16, 1'b0}) begin
            n_bad++;
            $display("FAIL full_fill: level=%0d ovf=%b, want 16 0", o_level, o_overflow);
        end
        bus.i_data_ready = 1'b1;
        strobe(8'hEE, 1'b1, 1'b1);
        n_cmp++;
        if ({o_level, o_overflow, o_count} !== {5'd16, 1'b0, 16'd17}) begin
            n_bad++;
            $display("FAIL full_pop_push: level=%0d ovf=%b count=%0d, want 16 0 17", o_level, o_overflow, o_count);
        end
        drain_all(40, "full");
        n_cmp++;
        if (got.size() != 17) begin
            n_bad++;
            $display("FAIL full_word_count: got %0d want 17", got.size());
        end else begin
            n_cmp++;
            if ({got[0], got[15], got[16]} !== {10'h0A0, 10'h0AF, 10'h3EE}) begin
                n_bad++;
                $display("FAIL full_order: first=%h 16th=%h last=%h, want 0a0 0af 3ee", got[0], got[15], got[16]);
            end
        end
    endtask

    task automatic test_drain_done();
        start_run();
        bus.i_data_ready = 1'b0;
        strobe(8'h31, 1'b0, 1'b0);
        strobe(8'h32, 1'b0, 1'b0);
        i_all_done = 1'b1;
        strobe(8'h33, 1'b0, 1'b0);
        i_all_done = 1'b0;
        strobe(8'h99, 1'b0, 1'b0);
        n_cmp++;
        if ({o_level, o_count, o_done} !== {5'd3, 16'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL drain_entry: level=%0d count=%0d done=%b, want 3 3 0", o_level, o_count, o_done);
        end
        for (int k = 0; k < 6; k++) begin
            bus.i_data_ready = (k % 2 == 0);
            tick();
            n_cmp++;
            if (o_done !== (k >= 4)) begin
                n_bad++;
                $display("FAIL drain_done[%0d]: got %b want %b", k, o_done, (k >= 4));
            end
        end
        n_cmp++;
        if (got.size() != 3 || {got[0], got[1], got[2]} !== {10'h031, 10'h032, 10'h033}) begin
            n_bad++;
            $display("FAIL drain_words: got %0d words, want 031 032 033", got.size());
        end
        bus.i_data_ready = 1'b1;
    endtask

    task automatic test_start_priority();
        start_run();
        strobe(8'h05, 1'b0, 1'b0);
        i_start    = 1'b1;
        i_all_done = 1'b1;
        tick();
        i_start    = 1'b0;
        i_all_done = 1'b0;
        n_cmp++;
        if ({o_count, o_checksum, o_done} !== '0) begin
            n_bad++;
            $display("FAIL prio_clear: count=%0d chk=%h done=%b, want 0 0 0", o_count, o_checksum, o_done);
        end
        strobe(8'h09, 1'b0, 1'b0);
        n_cmp++;
        if ({o_count, o_checksum} !== {16'd1, 16'h0009}) begin
            n_bad++;
            $display("FAIL prio_collect: count=%0d chk=%h, want 1 0009", o_count, o_checksum);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        vals[3] = 8'h44;
        bus.i_data_ready = 1'b1;
        start_run();
        for (int i = 0; i < 4; i++) begin
            strobe(vals[i], 1'b0, 1'b0);
            n_cmp++;
            if (o_level !== 5'd1) begin
                n_bad++;
                $display("FAIL b2b_level[%0d]: got %0d want 1", i, o_level);
            end
        end
        tick();
        // 0x11 -> 0x22^0x22=0x00 -> 0x33 -> 0x66^0x44=0x22
        n_cmp++;
        if ({o_count, o_checksum, o_overflow, o_level} !== {16'd4, 16'h0022, 1'b0, 5'd0}) begin
            n_bad++;
            $display("FAIL b2b_stats: count=%0d chk=%h ovf=%b level=%0d, want 4 0022 0 0",
                     o_count, o_checksum, o_overflow, o_level);
        end
        n_cmp++;
        if (got.size() != 4 || {got[0], got[1], got[2], got[3]} !== {10'h011, 10'h022, 10'h033, 10'h044}) begin
            n_bad++;
            $display("FAIL b2b_words: got %0d words, want 011 022 033 044", got.size());
        end
    endtask

    task automatic test_reset_mid_run();
        start_run();
        bus.i_data_ready = 1'b0;
        for (int i = 0; i < 5; i++) strobe(8'(8'h61 + i), 1'b0, 1'b0);
        n_cmp++;
        if (o_level !== 5'd5) begin
            n_bad++;
            $display("FAIL midreset_fill: level=%0d want 5", o_level);
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        n_cmp++;
        if ({bus.o_data, bus.o_data_valid, o_count, o_checksum, o_level, o_overflow, o_done} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: data=%h valid=%b count=%h chk=%h level=%0d ovf=%b done=%b, want all 0",
                     bus.o_data, bus.o_data_valid, o_count, o_checksum, o_level, o_overflow, o_done);
        end
        strobe(8'h77, 1'b0, 1'b0);
        n_cmp++;
        if ({o_count, o_level} !== '0) begin
            n_bad++;
            $display("FAIL midreset_idle: count=%0d level=%0d, want 0 0", o_count, o_level);
        end
        i_start = 1'b1;
        strobe(8'h42, 1'b0, 1'b0);
        i_start = 1'b0;
        n_cmp++;
        if ({o_count, o_level} !== '0) begin
            n_bad++;
            $display("FAIL start_strobe_ignored: count=%0d level=%0d, want 0 0", o_count, o_level);
        end
        strobe(8'h07, 1'b0, 1'b0);
        n_cmp++;
        if ({o_count, o_checksum, o_level, bus.o_data_valid, bus.o_data} !== {16'd1, 16'h0007, 5'd1, 1'b1, 10'h007}) begin
            n_bad++;
            $display("FAIL midreset_rerun: count=%0d chk=%h level=%0d valid=%b data=%h, want 1 0007 1 1 007",
                     o_count, o_checksum, o_level, bus.o_data_valid, bus.o_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset          = 1'b0;
        i_start          = 1'b0;
        i_result         = '0;
        i_valid_result   = 1'b0;
        i_carry          = 1'b0;
        i_zero_flag      = 1'b0;
        i_all_done       = 1'b0;
        bus.i_data_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop_push();
        test_drain_done();
        test_start_priority();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
